// File: rtl/lcd_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_command_sequencer
// Description : Drives the LCD instruction FSM. Runs the 4-bit power-on init
//               with raw nibbles, then issues config, DDRAM-address and
//               character commands one at a time, and owns the clk_cnt
//               timebase the instruction FSM decodes.
//               Optional feature macro: LCD_REFRESH_EN (rewrite the message
//               forever instead of halting after the first pass).
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_command_sequencer #(
    parameter int T_PWRON = 750000,
    parameter int T_GAP1  = 205000,
    parameter int T_GAP2  = 5000,
    parameter int T_GAP3  = 2000,
    parameter int T_CLEAR = 82000,
    parameter int E_PULSE = 12,
    parameter int CNT_MAX = 2300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_done,
    output logic       next_instruction,
    output logic [9:0] db,
    output logic [11:0] clk_cnt,
    output logic       init_active,
    output logic       init_e,
    output logic [3:0] init_d,
    output logic [4:0] msg_addr,
    input  logic [7:0] msg_data,
    output logic       seq_busy,
    output logic       err
);

    localparam logic [3:0] S_PWR_WAIT  = 4'd0;
    localparam logic [3:0] S_NIB_SETUP = 4'd1;
    localparam logic [3:0] S_NIB_PULSE = 4'd2;
    localparam logic [3:0] S_GAP       = 4'd3;
    localparam logic [3:0] S_ISSUE     = 4'd4;
    localparam logic [3:0] S_WAIT_DONE = 4'd5;
    localparam logic [3:0] S_WAIT_IDLE = 4'd6;
    localparam logic [3:0] S_CLR_WAIT  = 4'd7;
    localparam logic [3:0] S_PREFETCH  = 4'd8;
    localparam logic [3:0] S_HALT      = 4'd9;

    // Command list positions: 0-3 config, 4 line-1 address, 5-20 chars 0-15,
    // 21 line-2 address, 22-37 chars 16-31.
    localparam logic [5:0] c_STEP_CLEAR = 6'd3;
    localparam logic [5:0] c_STEP_LINE1 = 6'd4;
    localparam logic [5:0] c_STEP_LINE2 = 6'd21;
    localparam logic [5:0] c_STEP_LAST  = 6'd37;

    localparam logic [11:0] c_CNT_MAX = 12'(CNT_MAX);

    logic [3:0]  r_state;
    logic [19:0] r_timer;
    logic [1:0]  r_nib;
    logic [5:0]  r_step;
    logic        r_next;
    logic [9:0]  r_db;
    logic [11:0] r_clk_cnt;
    logic        r_init_active;
    logic        r_init_e;
    logic [3:0]  r_init_d;
    logic [4:0]  r_addr;
    logic        r_busy;
    logic        r_err;

    logic [19:0] w_gap_last;
    logic [9:0]  w_cmd;
    logic [5:0]  w_step_nxt;

    // Characters live at every list position past the line-1 address except
    // the line-2 address.
    function automatic logic is_char(input logic [5:0] s);
        return (s > c_STEP_LINE1) && (s != c_STEP_LINE2);
    endfunction

    function automatic logic [4:0] char_addr(input logic [5:0] s);
        return (s < c_STEP_LINE2) ? 5'(s - 6'd5) : 5'(s - 6'd6);
    endfunction

    assign w_step_nxt = 6'(r_step + 6'd1);

    // Gap length after the current init nibble, and the command at r_step.
    always_comb begin
        w_gap_last = 20'(T_GAP3 - 1);
        case (r_nib)
            2'd0:    w_gap_last = 20'(T_GAP1 - 1);
            2'd1:    w_gap_last = 20'(T_GAP2 - 1);
            default: w_gap_last = 20'(T_GAP3 - 1);
        endcase
        w_cmd = {2'b10, msg_data};
        case (r_step)
            6'd0:         w_cmd = 10'h028;
            6'd1:         w_cmd = 10'h006;
            6'd2:         w_cmd = 10'h00C;
            6'd3:         w_cmd = 10'h001;
            c_STEP_LINE1: w_cmd = 10'h080;
            c_STEP_LINE2: w_cmd = 10'h0C0;
            default:      w_cmd = {2'b10, msg_data};
        endcase
    end

    // Sequencer FSM with all outputs registered; clk_cnt saturates unless an issue clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_PWR_WAIT;
            r_timer       <= 20'd0;
            r_nib         <= 2'd0;
            r_step        <= 6'd0;
            r_next        <= 1'b0;
            r_db          <= 10'd0;
            r_clk_cnt     <= c_CNT_MAX;
            r_init_active <= 1'b1;
            r_init_e      <= 1'b0;
            r_init_d      <= 4'd0;
            r_addr        <= 5'd0;
            r_busy        <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_next <= 1'b0;
            if (r_clk_cnt != c_CNT_MAX) begin
                r_clk_cnt <= r_clk_cnt + 12'd1;
            end
            case (r_state)
                S_PWR_WAIT: begin
                    if (r_timer == 20'(T_PWRON - 1)) begin
                        r_timer  <= 20'd0;
                        r_init_d <= 4'h3;
                        r_state  <= S_NIB_SETUP;
                    end else begin
                        r_timer <= r_timer + 20'd1;
                    end
                end
                S_NIB_SETUP: begin
                    r_init_e <= 1'b1;
                    r_timer  <= 20'd0;
                    r_state  <= S_NIB_PULSE;
                end
                S_NIB_PULSE: begin
                    if (r_timer == 20'(E_PULSE - 1)) begin
                        r_init_e <= 1'b0;
                        r_timer  <= 20'd0;
                        r_state  <= S_GAP;
                    end else begin
                        r_timer <= r_timer + 20'd1;
                    end
                end
                S_GAP: begin
                    // First gap cycle doubles as the data hold time after E falls.
                    if (r_timer == w_gap_last) begin
                        r_timer <= 20'd0;
                        if (r_nib == 2'd3) begin
                            r_init_active <= 1'b0;
                            r_step        <= 6'd0;
                            r_state       <= S_ISSUE;
                        end else begin
                            r_nib    <= r_nib + 2'd1;
                            r_init_d <= (r_nib == 2'd2) ? 4'h2 : 4'h3;
                            r_state  <= S_NIB_SETUP;
                        end
                    end else begin
                        r_timer <= r_timer + 20'd1;
                    end
                end
                S_PREFETCH: begin
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_db      <= w_cmd;
                    r_next    <= 1'b1;
                    r_clk_cnt <= 12'd0;
                    r_state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (instr_done) begin
                        r_state <= S_WAIT_IDLE;
                    end else if (r_clk_cnt == c_CNT_MAX) begin
                        r_err   <= 1'b1;
                        r_step  <= 6'd0;
                        r_state <= S_ISSUE;
                    end
                end
                S_WAIT_IDLE: begin
                    // The instruction FSM is idle again only once clk_cnt saturates.
                    if (r_clk_cnt == c_CNT_MAX) begin
                        if (r_step == c_STEP_CLEAR) begin
                            r_timer <= 20'd0;
                            r_state <= S_CLR_WAIT;
                        end else if (r_step == c_STEP_LAST) begin
                            r_busy <= 1'b0;
`ifdef LCD_REFRESH_EN
                            r_step  <= c_STEP_LINE1;
                            r_state <= S_ISSUE;
`else
                            r_state <= S_HALT;
`endif
                        end else begin
                            r_step <= w_step_nxt;
                            if (is_char(w_step_nxt)) begin
                                r_addr  <= char_addr(w_step_nxt);
                                r_state <= S_PREFETCH;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                end
                S_CLR_WAIT: begin
                    if (r_timer == 20'(T_CLEAR - 1)) begin
                        r_timer <= 20'd0;
                        r_step  <= c_STEP_LINE1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_timer <= r_timer + 20'd1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_PWR_WAIT;
                end
            endcase
        end
    end

    assign next_instruction = r_next;
    assign db               = r_db;
    assign clk_cnt          = r_clk_cnt;
    assign init_active      = r_init_active;
    assign init_e           = r_init_e;
    assign init_d           = r_init_d;
    assign msg_addr         = r_addr;
    assign seq_busy         = r_busy;
    assign err              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_command_sequencer
// Description : Self-checking bench for lcd_command_sequencer: power-on init
//               timing, command list order, clear wait, done timeout, end of
//               message behaviour and asynchronous reset mid-message.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_command_sequencer;

    localparam int TP = 60;
    localparam int G1 = 40;
    localparam int G2 = 25;
    localparam int G3 = 15;
    localparam int TC = 150;
    localparam int EP = 12;
    localparam int CM = 300;
    localparam int BUDGET = 2 * CM + TC + 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_done = 1'b0;
    logic        next_instruction;
    logic [9:0]  db;
    logic [11:0] clk_cnt;
    logic        init_active;
    logic        init_e;
    logic [3:0]  init_d;
    logic [4:0]  msg_addr;
    logic [7:0]  msg_data;
    logic        seq_busy;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rom [32];
    logic [9:0] exp_cmd [38];
    int         exp_addr [38];

    lcd_command_sequencer #(
        .T_PWRON(TP), .T_GAP1(G1), .T_GAP2(G2), .T_GAP3(G3),
        .T_CLEAR(TC), .E_PULSE(EP), .CNT_MAX(CM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instr_done(instr_done),
        .next_instruction(next_instruction),
        .db(db),
        .clk_cnt(clk_cnt),
        .init_active(init_active),
        .init_e(init_e),
        .init_d(init_d),
        .msg_addr(msg_addr),
        .msg_data(msg_data),
        .seq_busy(seq_busy),
        .err(err)
    );

    always #5 clk = ~clk;

    // Message ROM: data valid one cycle after the address.
    always @(posedge clk) msg_data <= rom[msg_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Full command list as it should appear on db.
    task automatic build_exp();
        for (int i = 0; i < 38; i++) exp_addr[i] = -1;
        exp_cmd[0] = 10'h028;
        exp_cmd[1] = 10'h006;
        exp_cmd[2] = 10'h00C;
        exp_cmd[3] = 10'h001;
        exp_cmd[4] = 10'h080;
        exp_cmd[21] = 10'h0C0;
        for (int i = 0; i < 16; i++) begin
            exp_cmd[5 + i]   = {2'b10, rom[i]};
            exp_addr[5 + i]  = i;
            exp_cmd[22 + i]  = {2'b10, rom[16 + i]};
            exp_addr[22 + i] = 16 + i;
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_next"}, 32'(next_instruction), 32'd0);
        chk({pfx, "_db"}, 32'(db), 32'd0);
        chk({pfx, "_clk_cnt"}, 32'(clk_cnt), 32'(CM));
        chk({pfx, "_init_active"}, 32'(init_active), 32'd1);
        chk({pfx, "_init_e"}, 32'(init_e), 32'd0);
        chk({pfx, "_init_d"}, 32'(init_d), 32'd0);
        chk({pfx, "_msg_addr"}, 32'(msg_addr), 32'd0);
        chk({pfx, "_seq_busy"}, 32'(seq_busy), 32'd1);
        chk({pfx, "_err"}, 32'(err), 32'd0);
    endtask

    // Called at the negedge where reset was released; checks every cycle of init.
    task automatic init_check();
        int r [4];
        int last;
        logic [3:0] nib [4];
        logic e;
        logic [3:0] d;
        nib[0] = 4'h3; nib[1] = 4'h3; nib[2] = 4'h3; nib[3] = 4'h2;
        r[0] = TP;
        r[1] = r[0] + EP + G1 + 1;
        r[2] = r[1] + EP + G2 + 1;
        r[3] = r[2] + EP + G3 + 1;
        last = r[3] + EP + G3;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            e = 1'b0;
            d = 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (i >= r[k] && i < r[k] + EP) e = 1'b1;
                if (i >= r[k] - 1) d = nib[k];
            end
            chk($sformatf("init_e@%0d", i), 32'(init_e), 32'(e));
            chk($sformatf("init_d@%0d", i), 32'(init_d), 32'(d));
            chk($sformatf("init_active@%0d", i), 32'(init_active), 32'(i < last));
            chk($sformatf("init_next@%0d", i), 32'(next_instruction), 32'd0);
        end
    endtask

    task automatic wait_pulse(output int cyc, output logic [11:0] prev_cnt);
        logic [11:0] last;
        cyc = 0;
        last = clk_cnt;
        prev_cnt = last;
        while (cyc < BUDGET) begin
            last = clk_cnt;
            @(negedge clk);
            cyc++;
            if (next_instruction) break;
        end
        prev_cnt = last;
    endtask

    task automatic respond(input int dly);
        repeat (dly) @(negedge clk);
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
    endtask

    task automatic do_cmd(input int k, input bit give_done, input bit after_clear);
        int cyc;
        logic [11:0] pc;
        wait_pulse(cyc, pc);
        chk($sformatf("pulse[%0d]", k), 32'(next_instruction), 32'd1);
        chk($sformatf("db[%0d]", k), 32'(db), 32'(exp_cmd[k]));
        chk($sformatf("cnt_before_pulse[%0d]", k), 32'(pc), 32'(CM));
        chk($sformatf("cnt_cleared[%0d]", k), 32'(clk_cnt), 32'd0);
        if (exp_addr[k] >= 0)
            chk($sformatf("msg_addr[%0d]", k), 32'(msg_addr), 32'(exp_addr[k]));
        if (after_clear)
            chk("clear_wait", 32'(cyc > TC), 32'd1);
        if (give_done) respond($urandom_range(2, CM - 20));
    endtask

    initial begin
        int pulses;
        string line1;
        line1 = "HELLO, WORLD!   ";
        for (int i = 0; i < 16; i++) rom[i] = line1[i];
        for (int i = 16; i < 32; i++) rom[i] = 8'($urandom_range(8'h20, 8'h7E));
        build_exp();

        // Reset values while reset is held.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst");

        reset = 1'b0;
        init_check();

        // Done withheld on the third command: timeout restarts the list at 0x28.
        do_cmd(0, 1'b1, 1'b0);
        do_cmd(1, 1'b1, 1'b0);
        do_cmd(2, 1'b0, 1'b0);
        chk("err_before_timeout", 32'(err), 32'd0);
        do_cmd(0, 1'b1, 1'b0);
        chk("err_after_timeout", 32'(err), 32'd1);

        // Remainder of the first full pass.
        for (int k = 1; k < 38; k++) begin
            do_cmd(k, 1'b1, k == 4);
            chk($sformatf("busy[%0d]", k), 32'(seq_busy), 32'd1);
        end

`ifdef LCD_REFRESH_EN
        // Message rewritten; ROM change visible on the new pass.
        rom[0] = rom[0] ^ 8'h01;
        build_exp();
        do_cmd(4, 1'b1, 1'b0);
        chk("busy_after_pass", 32'(seq_busy), 32'd0);
        do_cmd(5, 1'b1, 1'b0);
        chk("err_sticky", 32'(err), 32'd1);
        for (int k = 6; k < 12; k++) do_cmd(k, 1'b1, 1'b0);
        do_cmd(12, 1'b0, 1'b0);
`else
        // Halt: no further pulses, db and clk_cnt frozen.
        pulses = 0;
        repeat (3 * CM) begin
            @(negedge clk);
            if (next_instruction) pulses++;
        end
        chk("halt_pulses", 32'(pulses), 32'd0);
        chk("halt_db", 32'(db), 32'(exp_cmd[37]));
        chk("halt_clk_cnt", 32'(clk_cnt), 32'(CM));
        chk("busy_after_pass", 32'(seq_busy), 32'd0);
        chk("err_sticky", 32'(err), 32'd1);
        chk("halt_msg_addr", 32'(msg_addr), 32'd31);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        init_check();
        for (int k = 0; k < 12; k++) do_cmd(k, 1'b1, k == 4);
        do_cmd(12, 1'b0, 1'b0);
`endif

        // Asynchronous reset during char 7.
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset("mid");
        @(negedge clk);
        reset = 1'b0;
        init_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
